// File: rtl/hybrid_log_encoder_pkg.sv
// hybrid_log_encoder_pkg: shared rounding-mode constants and exponent-width helper
package hybrid_log_encoder_pkg;
  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_NEAR  = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hybrid_lod_channel.sv
// hybrid_lod_channel: leading-one detect, mantissa extract and optional round for one magnitude
//   mag  : unsigned magnitude |x|
//   zero : magnitude is zero
//   exp  : index of the most significant 1 (0 when zero)
//   mant : W_MANT bits below the leading one, left-aligned
module hybrid_lod_channel
  import hybrid_log_encoder_pkg::*;
#(
  parameter int W_IN   = 16,
  parameter int W_MANT = 4,
  parameter int ROUND  = ROUND_TRUNC,
  localparam int W_EXP = clog2(W_IN)
) (
  input  logic [W_IN-1:0]   mag,
  output logic              zero,
  output logic [W_EXP-1:0]  exp,
  output logic [W_MANT-1:0] mant
);
  logic [W_EXP-1:0] lead;
  logic [W_MANT:0]  frac;
  logic [W_MANT:0]  sum;
  always_comb begin
    lead = '0;
    for (int i = 0; i < W_IN; i++) lead = mag[i] ? W_EXP'(i) : lead;
    // normalise so the leading one sits at the MSB, then keep mantissa plus the first discarded bit
    frac = (W_MANT+1)'((mag << (W_EXP'(W_IN - 1) - lead)) >> (W_IN - 2 - W_MANT));
    sum  = {1'b0, frac[W_MANT:1]} + ((ROUND == ROUND_NEAR) ? (W_MANT+1)'(frac[0]) : '0);
    zero = ~|mag;
    // a mantissa carry bumps the exponent; at the top exponent it saturates instead
    exp  = !sum[W_MANT] ? lead : (lead == W_EXP'(W_IN - 1)) ? lead : lead + 1'b1;
    mant = !sum[W_MANT] ? sum[W_MANT-1:0] : (lead == W_EXP'(W_IN - 1)) ? '1 : '0;
  end
endmodule

// File: rtl/hybrid_log_encoder.sv
// hybrid_log_encoder: 2-stage valid/ready pipeline converting N_CH signed words to sign/zero/exp/mant
//   clock, resetn (async, active-low)
//   in_valid/in_ready/in_data   : input handshake, channel c at in_data[c*W_IN +: W_IN]
//   out_valid/out_ready         : output handshake
//   out_sign/out_zero/out_exp/out_mant : per-channel encoded fields
module hybrid_log_encoder
  import hybrid_log_encoder_pkg::*;
#(
  parameter int W_IN   = 16,
  parameter int W_MANT = 4,
  parameter int N_CH   = 4,
  parameter int ROUND  = ROUND_TRUNC,
  localparam int W_EXP = clog2(W_IN)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*W_IN-1:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH-1:0]          out_sign,
  output logic [N_CH-1:0]          out_zero,
  output logic [N_CH*W_EXP-1:0]    out_exp,
  output logic [N_CH*W_MANT-1:0]   out_mant
);
  logic                   s1_valid_q, s1_valid_d;
  logic [N_CH-1:0]        s1_sign_q, s1_sign_d;
  logic [N_CH*W_IN-1:0]   s1_mag_q, s1_mag_d;
  logic                   out_valid_q, out_valid_d;
  logic [N_CH-1:0]        out_sign_q, out_sign_d;
  logic [N_CH-1:0]        out_zero_q, out_zero_d;
  logic [N_CH*W_EXP-1:0]  out_exp_q, out_exp_d;
  logic [N_CH*W_MANT-1:0] out_mant_q, out_mant_d;
  logic [N_CH-1:0]        lod_zero;
  logic [N_CH*W_EXP-1:0]  lod_exp;
  logic [N_CH*W_MANT-1:0] lod_mant;
  logic                   s1_load, s2_load, load_in, load_out;
  logic [W_IN-1:0]        x;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    hybrid_lod_channel #(.W_IN(W_IN), .W_MANT(W_MANT), .ROUND(ROUND)) u_lod (
      .mag  (s1_mag_q[c*W_IN +: W_IN]),
      .zero (lod_zero[c]),
      .exp  (lod_exp[c*W_EXP +: W_EXP]),
      .mant (lod_mant[c*W_MANT +: W_MANT])
    );
  end
  always_comb begin
    s2_load     = !out_valid_q || out_ready;
    s1_load     = !s1_valid_q || s2_load;
    load_in     = s1_load && in_valid;
    load_out    = s2_load && s1_valid_q;
    in_ready    = s1_load;
    s1_valid_d  = s1_load ? in_valid : s1_valid_q;
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    x           = '0;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    for (int c = 0; c < N_CH; c++) begin
      x = in_data[c*W_IN +: W_IN];
      s1_sign_d[c] = load_in ? x[W_IN-1] : s1_sign_q[c];
      // W_IN-bit unsigned negate maps the most negative value onto 2^(W_IN-1)
      s1_mag_d[c*W_IN +: W_IN] = load_in ? (x[W_IN-1] ? -x : x) : s1_mag_q[c*W_IN +: W_IN];
    end
    out_sign_d = load_out ? s1_sign_q : out_sign_q;
    out_zero_d = load_out ? lod_zero : out_zero_q;
    out_exp_d  = load_out ? lod_exp : out_exp_q;
    out_mant_d = load_out ? lod_mant : out_mant_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= '0;
      out_zero_q  <= '0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_exp_q   <= out_exp_d;
      out_mant_q  <= out_mant_d;
    end
  end
  always_ff @(posedge clock) begin
    s1_sign_q <= s1_sign_d;
    s1_mag_q  <= s1_mag_d;
  end
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;
endmodule

// File: tb/tb_hybrid_log_encoder.sv
// tb_hybrid_log_encoder: scoreboard bench driving truncating and rounding instances in lockstep
module tb_hybrid_log_encoder;
  logic        clock, resetn, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready0, in_ready1, out_valid0, out_valid1;
  logic [3:0]  sign0, sign1, zero0, zero1;
  logic [15:0] exp0, exp1, mant0, mant1;
  typedef struct packed {
    logic [15:0] v; logic s; logic z;
    logic [3:0] e0; logic [3:0] m0; logic [3:0] e1; logic [3:0] m1;
  } ent_t;
  typedef struct packed { logic [39:0] r0; logic [39:0] r1; } exp_t;
  ent_t tbl [12];
  exp_t sb [$];
  int   errors = 0, checks = 0, nout = 0;
  bit   saw_block = 0;
  hybrid_log_encoder #(.W_IN(16), .W_MANT(4), .N_CH(4), .ROUND(0)) d0 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sign(sign0), .out_zero(zero0),
    .out_exp(exp0), .out_mant(mant0));
  hybrid_log_encoder #(.W_IN(16), .W_MANT(4), .N_CH(4), .ROUND(1)) d1 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sign(sign1), .out_zero(zero1),
    .out_exp(exp1), .out_mant(mant1));
  initial clock = 0;
  always #5 clock = ~clock;
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [39:0] pack_exp(int k, bit rnd);
    logic [3:0] s, z;
    logic [15:0] e, m;
    ent_t t;
    for (int c = 0; c < 4; c++) begin
      t = tbl[(k + c) % 12];
      s[c] = t.s;
      z[c] = t.z;
      e[c*4 +: 4] = rnd ? t.e1 : t.e0;
      m[c*4 +: 4] = rnd ? t.m1 : t.m0;
    end
    return {s, z, e, m};
  endfunction
  task automatic send(int k);
    int n;
    @(negedge clock);
    in_valid = 1;
    for (int c = 0; c < 4; c++) in_data[c*16 +: 16] = tbl[(k + c) % 12].v;
    #1;
    n = 0;
    while (!(in_ready0 && in_ready1)) begin
      saw_block = 1;
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        $fatal(1, "input never accepted");
      end
      @(negedge clock);
      #1;
    end
    @(posedge clock);
    sb.push_back('{pack_exp(k, 0), pack_exp(k, 1)});
  endtask
  task automatic idle();
    @(negedge clock);
    in_valid = 0;
  endtask
  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    chk(name, 64'(sb.size()), 64'd0);
  endtask
  initial begin : monitor
    bit stall;
    logic [40:0] prev0, prev1;
    exp_t e;
    stall = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!resetn) stall = 0;
      else begin
        if (stall) begin
          chk("hold_trunc", {out_valid0, sign0, zero0, exp0, mant0}, 64'(prev0));
          chk("hold_round", {out_valid1, sign1, zero1, exp1, mant1}, 64'(prev1));
        end
        if (out_valid0 && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", 64'(out_valid0), 64'd0);
          else begin
            e = sb.pop_front();
            chk("out_trunc", {sign0, zero0, exp0, mant0}, 64'(e.r0));
            chk("out_round", {out_valid1, sign1, zero1, exp1, mant1}, 64'({1'b1, e.r1}));
            nout++;
          end
        end
        stall = out_valid0 && !out_ready;
        prev0 = {out_valid0, sign0, zero0, exp0, mant0};
        prev1 = {out_valid1, sign1, zero1, exp1, mant1};
      end
    end
  end
  initial begin : stim
    int base;
    tbl[0]  = '{16'h002D, 1'b0, 1'b0, 4'd5,  4'b0110, 4'd5,  4'b0111};
    tbl[1]  = '{16'h8000, 1'b1, 1'b0, 4'd15, 4'b0000, 4'd15, 4'b0000};
    tbl[2]  = '{16'hFFFF, 1'b1, 1'b0, 4'd0,  4'b0000, 4'd0,  4'b0000};
    tbl[3]  = '{16'h0005, 1'b0, 1'b0, 4'd2,  4'b0100, 4'd2,  4'b0100};
    tbl[4]  = '{16'h7FFF, 1'b0, 1'b0, 4'd14, 4'b1111, 4'd15, 4'b0000};
    tbl[5]  = '{16'h0000, 1'b0, 1'b1, 4'd0,  4'b0000, 4'd0,  4'b0000};
    tbl[6]  = '{16'h0001, 1'b0, 1'b0, 4'd0,  4'b0000, 4'd0,  4'b0000};
    tbl[7]  = '{16'hFFD3, 1'b1, 1'b0, 4'd5,  4'b0110, 4'd5,  4'b0111};
    tbl[8]  = '{16'h0018, 1'b0, 1'b0, 4'd4,  4'b1000, 4'd4,  4'b1000};
    tbl[9]  = '{16'h1234, 1'b0, 1'b0, 4'd12, 4'b0010, 4'd12, 4'b0010};
    tbl[10] = '{16'h0FF8, 1'b0, 1'b0, 4'd11, 4'b1111, 4'd12, 4'b0000};
    tbl[11] = '{16'h8001, 1'b1, 1'b0, 4'd14, 4'b1111, 4'd15, 4'b0000};
    in_valid = 0;
    in_data = '0;
    out_ready = 1;
    resetn = 1;
    #1 resetn = 0;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_valid", {out_valid0, out_valid1}, 64'd0);
    chk("reset_fields", {sign0, zero0, exp0, mant0, sign1, zero1, exp1, mant1}, 64'd0);
    #2 resetn = 1;
    @(negedge clock);
    #1;
    chk("reset_in_ready", {in_ready0, in_ready1}, 64'd3);
    send(0);
    idle();
    #2 chk("latency_1cyc", 64'(out_valid0), 64'd0);
    @(negedge clock);
    #2 chk("latency_2cyc", 64'(out_valid0), 64'd1);
    send(4);
    idle();
    drain("drain_directed");
    base = nout;
    saw_block = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send(k + 2);
        idle();
      end
      begin
        repeat (3) @(negedge clock);
        out_ready = 0;
        repeat (3) @(negedge clock);
        out_ready = 1;
      end
    join
    drain("drain_stream");
    chk("stream_count", 64'(nout - base), 64'd10);
    chk("stream_backpressure", 64'(saw_block), 64'd1);
    out_ready = 0;
    send(1);
    send(2);
    idle();
    repeat (2) @(negedge clock);
    #3 resetn = 0;
    #1;
    chk("midreset_valid", {out_valid0, out_valid1}, 64'd0);
    chk("midreset_fields", {sign0, zero0, exp0, mant0, sign1, zero1, exp1, mant1}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    #3 resetn = 1;
    out_ready = 1;
    repeat (4) @(negedge clock);
    #2 chk("post_reset_quiet", {out_valid0, out_valid1}, 64'd0);
    send(6);
    idle();
    drain("drain_post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hybrid_log_encoder.md
HYBRID_LOG_ENCODER -- requirements
Module: hybrid_log_encoder

Interface
REQ-001 SHALL have parameter W_IN, default 16, two's-complement input width per channel (4..32).
REQ-002 SHALL have parameter W_MANT, default 4, mantissa width per channel (1..W_IN-2).
REQ-003 SHALL have parameter N_CH, default 4, number of parallel channels sharing one handshake.
REQ-004 SHALL have parameter ROUND, default 0: 0 = truncate, 1 = round-half-up on mantissa.
REQ-005 SHALL derive W_EXP = clog2(W_IN) as a localparam.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 resetn  input  1  reset, asynchronous, active-low.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  N_CH*W_IN  channel c at bits [c*W_IN +: W_IN], signed.
REQ-011 out_valid  output  1  output fields valid.
REQ-012 out_ready  input  1  downstream accepts outputs.
REQ-013 out_sign  output  N_CH  sign bit per channel.
REQ-014 out_zero  output  N_CH  channel magnitude is zero.
REQ-015 out_exp  output  N_CH*W_EXP  leading-one position of |x|.
REQ-016 out_mant  output  N_CH*W_MANT  W_MANT bits below the leading one.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 registers sign and |x|; S2 registers leading-one detection, mantissa extraction, rounding.
REQ-018 Latency SHALL be 2 cycles from accepted input to out_valid when out_ready is held high; throughput 1 vector/cycle.
REQ-019 Transfer SHALL occur on valid&&ready at each port; out_* SHALL hold stable while out_valid&&!out_ready.
REQ-020 A stage SHALL load when empty or when its content moves on that cycle; in_ready = !S1_valid || S1 advances (combinational from out_ready permitted).
REQ-021 |x| SHALL be held as W_IN-bit unsigned; -2^(W_IN-1) SHALL yield 2^(W_IN-1) without overflow.
REQ-022 out_exp SHALL be the index of the most significant 1 of |x|.
REQ-023 out_mant SHALL be the W_MANT bits directly below the leading one, left-aligned, zero-padded when out_exp < W_MANT.
REQ-024 ROUND=1: SHALL add the first discarded bit to the mantissa; on mantissa carry-out, out_exp+1 and out_mant=0.
REQ-025 If rounding pushes out_exp above W_IN-1, SHALL saturate to out_exp=W_IN-1, out_mant=all ones.
REQ-026 x=0 SHALL give out_zero=1, out_sign=0, out_exp=0, out_mant=0.
REQ-027 Channels SHALL be fully independent in data; handshake is shared.
REQ-028 No vector SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-029 On resetn low: S1_valid, S2_valid, out_valid = 0; out_sign, out_zero, out_exp, out_mant = 0; in_ready = 1 after release.
REQ-030 Reset mid-stream SHALL discard all in-flight vectors; no out_valid until a new input is accepted.
REQ-031 Data registers MAY skip reset except the output registers in REQ-029.

Structure
REQ-032 A shared package SHALL hold W_EXP derivation function (clog2) and the ROUND mode constants (ROUND_TRUNC=0, ROUND_NEAR=1).
REQ-033 Per-channel leading-one detect plus mantissa/round SHALL be one sub-module, hybrid_lod_channel, instantiated N_CH times via generate.
REQ-034 Handshake/valid logic SHALL live once in the top module.

Verification (W_IN=16, W_MANT=4, N_CH=4)
REQ-035 ch0=0x002D, ROUND=0 -> sign0, exp5, mant 0110; ROUND=1 -> exp5, mant 0111; 2 cycles later.
REQ-036 ch1=0x8000 -> sign1, exp15, mant0000; ch2=0xFFFF -> sign1, exp0, mant0000; ch3=0x0005 -> exp2, mant0100.
REQ-037 ch0=0x7FFF, ROUND=1 -> exp15, mant0000, zero0; ch1=0x0000 -> zero1, all fields 0.
REQ-038 Streaming 10 vectors, out_ready low cycles 3-5 -> in_ready low after both stages full; all 10 out in order, none lost/duplicated.
REQ-039 resetn pulsed low with 2 vectors in flight -> out_valid 0 immediately, outputs 0, next output only from post-reset input.
